error_collector: RTL and testbench

Sink for the linear regressor's 20-bit error stream. It captures every signed error sample the regressor emits into an on-chip buffer and accumulates the sum of squared errors. When the regressor signals completion, it reports the totals, and the buffered samples can be read back through a simple read port. It sits between the regressor's `Vect_E`/`ready` outputs and the checking or readout logic.

---
 rtl/error_collector.sv | 118 +++++++++++
 tb/tb_error_collector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/error_collector.sv
// Error-stream sink: buffers signed 20-bit samples and accumulates the sum of squares.
// Optional ERR_MAXABS_EN builds the running max |err| tracker; otherwise max_abs is 0.
module error_collector #(
  parameter int DEPTH = 128,
  parameter int SSE_W = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      err_valid,
  input  logic [19:0]               err_in,
  input  logic                      ready,
  input  logic [$clog2(DEPTH)-1:0]  rd_addr,
  output logic [19:0]               rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic [SSE_W-1:0]          sse,
  output logic [19:0]               max_abs,
  output logic                      overflow,
  output logic                      busy,
  output logic                      done
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, COLLECT, FINISH, DONE} state_t;
  state_t state;

  logic [19:0]        mem [DEPTH];
  logic signed [19:0] e_s;
  logic signed [39:0] sq;
  logic [39:0]        sq_r;
  logic               sq_vld;
  logic               fin_cnt;
  logic               full;
  logic               acc;

  assign e_s  = err_in;
  assign sq   = e_s * e_s;
  assign full = (count == CW'(DEPTH));
  // start wins over a same-cycle sample, so the sample is never accepted
  assign acc  = !rst && !start && (state == COLLECT) && err_valid && !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      sse      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sq_r     <= '0;
      sq_vld   <= 1'b0;
      fin_cnt  <= 1'b0;
    end else if (start) begin
      state    <= COLLECT;
      count    <= '0;
      sse      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b1;
      done     <= 1'b0;
      sq_vld   <= 1'b0;
      fin_cnt  <= 1'b0;
    end else begin
      sq_vld <= 1'b0;
      if (sq_vld) sse <= sse + SSE_W'(sq_r);
      case (state)
        COLLECT: begin
          if (acc) begin
            count  <= count + 1'b1;
            sq_r   <= sq;
            sq_vld <= 1'b1;
          end else if (err_valid && full) begin
            overflow <= 1'b1;
          end
          if (ready) begin
            state   <= FINISH;
            fin_cnt <= 1'b0;
          end
        end
        // two cycles: square register, then accumulator
        FINISH: begin
          if (fin_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            fin_cnt <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (acc) mem[count[AW-1:0]] <= err_in;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef ERR_MAXABS_EN
  logic [19:0] abs_v;
  // -524288 has no positive 20-bit counterpart; clamp to the largest magnitude
  assign abs_v = !err_in[19]          ? err_in :
                 (err_in == 20'h80000) ? 20'h7FFFF : -err_in;

  always_ff @(posedge clk) begin
    if (rst || start)              max_abs <= '0;
    else if (acc && abs_v > max_abs) max_abs <= abs_v;
  end
`else
  assign max_abs = '0;
`endif

endmodule

// File: tb/tb_error_collector.sv
// Directed bench for error_collector: default-depth instance plus a DEPTH=4 instance
// sharing stimulus, used for the saturation/overflow case.
module tb_error_collector;
  logic        clk = 1'b0;
  logic        rst, start, err_valid, ready;
  logic [19:0] err_in;
  logic [6:0]  rd_addr;
  logic [1:0]  rd_addr4;

  logic [19:0] rd_data, rd_data4, max_abs, max_abs4;
  logic [7:0]  count;
  logic [2:0]  count4;
  logic [47:0] sse, sse4;
  logic        overflow, busy, done, overflow4, busy4, done4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  error_collector dut (
    .clk(clk), .rst(rst), .start(start), .err_valid(err_valid), .err_in(err_in),
    .ready(ready), .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .sse(sse),
    .max_abs(max_abs), .overflow(overflow), .busy(busy), .done(done)
  );

  error_collector #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .err_valid(err_valid), .err_in(err_in),
    .ready(ready), .rd_addr(rd_addr4), .rd_data(rd_data4), .count(count4), .sse(sse4),
    .max_abs(max_abs4), .overflow(overflow4), .busy(busy4), .done(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] exp_max(input logic [19:0] v);
`ifdef ERR_MAXABS_EN
    return v;
`else
    return 20'h0 & v;
`endif
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; err_valid = 1'b0; ready = 1'b0;
    err_in = '0; rd_addr = '0; rd_addr4 = '0;
    tick(); tick();
    check("rst_rd_data", rd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    repeat (5) tick();
    check("idle_count", count, 0);
    check("idle_sse", sse, 0);
    check("idle_max_abs", max_abs, 0);
    check("idle_overflow", overflow, 0);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // samples 3, -4, 5 then ready
    start = 1'b1; tick(); start = 1'b0;
    check("start_busy", busy, 1);
    err_valid = 1'b1;
    err_in = 20'd3;      tick();
    check("count_1cyc", count, 1);
    err_in = 20'hFFFFC;  tick();
    check("sse_2cyc", sse, 9);
    err_in = 20'd5;      tick();
    err_valid = 1'b0; ready = 1'b1; tick(); ready = 1'b0;
    check("fin1_busy", busy, 1);
    check("fin1_done", done, 0);
    tick();
    check("fin2_done", done, 0);
    tick();
    check("basic_done", done, 1);
    check("basic_busy", busy, 0);
    check("basic_count", count, 3);
    check("basic_sse", sse, 50);
    check("basic_max_abs", max_abs, exp_max(20'd5));
    for (int a = 0; a < 3; a++) begin
      rd_addr = 7'(a); tick();
      case (a)
        0: check("rd0", rd_data, 20'd3);
        1: check("rd1", rd_data, 20'hFFFFC);
        default: check("rd2", rd_data, 20'd5);
      endcase
    end
    err_valid = 1'b1; err_in = 20'd9; tick(); err_valid = 1'b0;
    check("done_ignores_valid", count, 3);

    // six samples of 1000 into the depth-4 instance
    start = 1'b1; tick(); start = 1'b0;
    err_valid = 1'b1; err_in = 20'd1000;
    repeat (6) tick();
    err_valid = 1'b0; ready = 1'b1; tick(); ready = 1'b0;
    tick(); tick();
    check("d4_count", count4, 4);
    check("d4_sse", sse4, 64'd4000000);
    check("d4_overflow", overflow4, 1);
    check("d4_done", done4, 1);
    check("d128_count6", count, 6);
    check("d128_overflow", overflow, 0);
    rd_addr4 = 2'd3; tick();
    check("d4_rd3", rd_data4, 20'd1000);

    // most negative sample together with ready
    start = 1'b1; tick(); start = 1'b0;
    err_valid = 1'b1; ready = 1'b1; err_in = 20'h80000; tick();
    err_valid = 1'b0; ready = 1'b0;
    tick();
    check("neg_done_early", done, 0);
    tick();
    check("neg_done", done, 1);
    check("neg_count", count, 1);
    check("neg_sse", sse, 64'd1 << 38);
    check("neg_max_abs", max_abs, exp_max(20'h7FFFF));

    // restart mid-collect; the sample in the start cycle is dropped
    start = 1'b1; tick(); start = 1'b0;
    err_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      err_in = 20'(i + 1); tick();
    end
    check("pre_restart_count", count, 10);
    check("pre_restart_ovf4", overflow4, 1);
    start = 1'b1; err_in = 20'd100; tick(); start = 1'b0;
    check("restart_count", count, 0);
    err_in = 20'd7; ready = 1'b1; tick();
    err_valid = 1'b0; ready = 1'b0;
    tick(); tick();
    check("restart_done", done, 1);
    check("restart_count1", count, 1);
    check("restart_sse", sse, 49);
    check("restart_overflow", overflow, 0);
    check("restart_ovf4", overflow4, 0);
    check("restart_max_abs", max_abs, exp_max(20'd7));

    // reset while in FINISH
    start = 1'b1; tick(); start = 1'b0;
    err_valid = 1'b1; err_in = 20'd9; tick();
    err_valid = 1'b0; ready = 1'b1; tick(); ready = 1'b0;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_fin_busy", busy, 0);
    check("rst_fin_done", done, 0);
    check("rst_fin_sse", sse, 0);
    err_valid = 1'b1; err_in = 20'd11; tick(); err_valid = 1'b0;
    tick(); tick();
    check("post_rst_count", count, 0);
    check("post_rst_sse", sse, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_max_abs", max_abs, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
